// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder-buffer types and default sizes
// Contents:
//   ROB_SIZE, ROB_DATA_W, ROB_REG_W : default geometry, shared with the pointer manager
//   rob_entry_t                     : one ROB entry (valid, done, exc, has_dest, dest, data)
//   commit_state_t                  : retire FSM states {RUN, FLUSH}
package rob_pkg;

    localparam int ROB_SIZE   = 16;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_REG_W  = 5;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic                  has_dest;
        logic [ROB_REG_W-1:0]  dest;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } commit_state_t;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// rtl/rob_commit_ctrl_if.sv - allocate/writeback/commit bundle of the ROB retire block
// Signals:
//   alloc_*        dispatch-side allocation at the tail
//   wb_*           execution writeback by ROB tag
//   head_i         current head index from the pointer manager
//   commit_*       retire port towards the architectural register file
//   update_head_o  head-advance pulse, flush_o pipeline flush, busy_o any entry valid
// Modports: master = surrounding pipeline, slave = rob_commit_ctrl.
interface rob_commit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              alloc_valid_i;
    logic [ADDR_W-1:0] alloc_tag_i;
    logic [REG_W-1:0]  alloc_dest_i;
    logic              alloc_has_dest_i;
    logic              wb_valid_i;
    logic [ADDR_W-1:0] wb_tag_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              wb_exc_i;
    logic [ADDR_W-1:0] head_i;
    logic              commit_ready_i;
    logic              commit_valid_o;
    logic [ADDR_W-1:0] commit_tag_o;
    logic [REG_W-1:0]  commit_dest_o;
    logic              commit_we_o;
    logic [DATA_W-1:0] commit_data_o;
    logic              update_head_o;
    logic              flush_o;
    logic              busy_o;

    modport master (
        output alloc_valid_i, alloc_tag_i, alloc_dest_i, alloc_has_dest_i,
        output wb_valid_i, wb_tag_i, wb_data_i, wb_exc_i,
        output head_i, commit_ready_i,
        input  commit_valid_o, commit_tag_o, commit_dest_o, commit_we_o,
        input  commit_data_o, update_head_o, flush_o, busy_o
    );

    modport slave (
        input  alloc_valid_i, alloc_tag_i, alloc_dest_i, alloc_has_dest_i,
        input  wb_valid_i, wb_tag_i, wb_data_i, wb_exc_i,
        input  head_i, commit_ready_i,
        output commit_valid_o, commit_tag_o, commit_dest_o, commit_we_o,
        output commit_data_o, update_head_o, flush_o, busy_o
    );
endinterface

// File: rtl/rob_status_array.sv
// rtl/rob_status_array.sv - ROB entry storage with alloc/writeback/clear write ports and a head read port
// Ports:
//   clk, rst_n                     clock, async active-low reset (clears valid/done/exc)
//   alloc_en/idx/dest/has_dest     allocate an entry: valid=1, done=0, exc=0
//   wb_en/idx/data/exc             complete a valid entry: done=1, data and exc captured
//   clr_en/idx                     retire an entry: valid=0
//   flush_en                       clear every entry
//   head_idx -> head_*             combinational read of the head entry
//   any_valid                      OR of all valid bits
module rob_status_array
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_SIZE,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int DATA_W = ROB_DATA_W,
    parameter int REG_W  = ROB_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_en,
    input  logic [IDX_W-1:0]  alloc_idx,
    input  logic [REG_W-1:0]  alloc_dest,
    input  logic              alloc_has_dest,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_exc,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx,
    input  logic              flush_en,
    input  logic [IDX_W-1:0]  head_idx,
    output logic              head_valid,
    output logic              head_done,
    output logic              head_exc,
    output logic              head_has_dest,
    output logic [REG_W-1:0]  head_dest,
    output logic [DATA_W-1:0] head_data,
    output logic              any_valid
);
    logic [DEPTH-1:0]  valid_q, done_q, exc_q, has_dest_q;
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [DEPTH-1:0]  alloc_hit, wb_hit, clr_hit;

    // Writebacks only land on entries that are currently valid.
    always_comb begin
        alloc_hit = '0;
        wb_hit    = '0;
        clr_hit   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_hit[i] = alloc_en && (alloc_idx == IDX_W'(i));
            wb_hit[i]    = wb_en && (wb_idx == IDX_W'(i)) && valid_q[i];
            clr_hit[i]   = clr_en && (clr_idx == IDX_W'(i));
        end
    end

    // Priority per entry: flush > alloc > retire-clear > writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else if (flush_en) begin
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_hit[i]) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                    exc_q[i]   <= 1'b0;
                end else if (clr_hit[i]) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                    exc_q[i]   <= 1'b0;
                end else if (wb_hit[i]) begin
                    done_q[i]  <= 1'b1;
                    exc_q[i]   <= wb_exc;
                end
            end
        end
    end

    // Payload is only meaningful while valid/done say so, hence no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_hit[i]) begin
                dest_q[i]     <= alloc_dest;
                has_dest_q[i] <= alloc_has_dest;
            end
            if (wb_hit[i] && !alloc_hit[i]) begin
                data_q[i] <= wb_data;
            end
        end
    end

    assign head_valid    = valid_q[head_idx];
    assign head_done     = done_q[head_idx];
    assign head_exc      = exc_q[head_idx];
    assign head_has_dest = has_dest_q[head_idx];
    assign head_dest     = dest_q[head_idx];
    assign head_data     = data_q[head_idx];
    assign any_valid     = |valid_q;

endmodule

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - ROB retire controller: in-order commit, head advance, exception flush
// Ports:
//   clk_i            clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   rob_if (slave)   alloc_*, wb_*, head_i, commit_ready_i in;
//                    commit_valid/tag/dest/we/data_o, update_head_o, flush_o, busy_o out
//   retired_count_o  (ROB_COMMIT_STATS_EN only) 32-bit wrapping count of head advances
//   flush_count_o    (ROB_COMMIT_STATS_EN only) 16-bit saturating count of flush cycles
// Build option: define ROB_COMMIT_STATS_EN to add the two statistics counters.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int ROBsize  = ROB_SIZE,
    parameter int addrSize = $clog2(ROBsize),
    parameter int DATA_W   = ROB_DATA_W,
    parameter int REG_W    = ROB_REG_W
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    rob_commit_if.slave rob_if
`ifdef ROB_COMMIT_STATS_EN
    ,
    output logic [31:0] retired_count_o,
    output logic [15:0] flush_count_o
`endif
);
    commit_state_t     state_q, state_d;
    logic              in_run, in_flush;
    logic              commit_valid, update_head;
    logic              head_valid, head_done, head_exc, head_has_dest;
    logic [REG_W-1:0]  head_dest;
    logic [DATA_W-1:0] head_data;
    logic              any_valid;

    assign in_run   = (state_q == RUN);
    assign in_flush = (state_q == FLUSH);

    rob_status_array #(
        .DEPTH  (ROBsize),
        .IDX_W  (addrSize),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_status (
        .clk            (clk_i),
        .rst_n          (reset_n_i),
        .alloc_en       (rob_if.alloc_valid_i & in_run),
        .alloc_idx      (rob_if.alloc_tag_i),
        .alloc_dest     (rob_if.alloc_dest_i),
        .alloc_has_dest (rob_if.alloc_has_dest_i),
        .wb_en          (rob_if.wb_valid_i & in_run),
        .wb_idx         (rob_if.wb_tag_i),
        .wb_data        (rob_if.wb_data_i),
        .wb_exc         (rob_if.wb_exc_i),
        .clr_en         (update_head),
        .clr_idx        (rob_if.head_i),
        .flush_en       (in_flush),
        .head_idx       (rob_if.head_i),
        .head_valid     (head_valid),
        .head_done      (head_done),
        .head_exc       (head_exc),
        .head_has_dest  (head_has_dest),
        .head_dest      (head_dest),
        .head_data      (head_data),
        .any_valid      (any_valid)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A completed head either retires or, if it faulted, sends us to a
    // single FLUSH cycle that wipes every entry.
    always_comb begin
        state_d      = state_q;
        commit_valid = 1'b0;
        case (state_q)
            RUN: begin
                if (head_valid && head_done) begin
                    if (head_exc) begin
                        state_d = FLUSH;
                    end else begin
                        commit_valid = 1'b1;
                    end
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign update_head = commit_valid & rob_if.commit_ready_i;

    assign rob_if.commit_valid_o = commit_valid;
    assign rob_if.commit_tag_o   = rob_if.head_i;
    assign rob_if.commit_dest_o  = head_dest;
    assign rob_if.commit_we_o    = commit_valid & head_has_dest;
    assign rob_if.commit_data_o  = head_data;
    assign rob_if.update_head_o  = update_head;
    assign rob_if.flush_o        = in_flush;
    assign rob_if.busy_o         = any_valid;

`ifdef ROB_COMMIT_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            retired_count_o <= '0;
            flush_count_o   <= '0;
        end else begin
            if (update_head) begin
                retired_count_o <= retired_count_o + 32'd1;
            end
            if (in_flush && (flush_count_o != 16'hFFFF)) begin
                flush_count_o <= flush_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - directed vector bench for rob_commit_ctrl (ROBsize=8)
module tb_rob_commit_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rob_commit_if #(.ADDR_W(3), .DATA_W(32), .REG_W(5)) bus ();

`ifdef ROB_COMMIT_STATS_EN
    logic [31:0] retired_count;
    logic [15:0] flush_count;
`endif

    rob_commit_ctrl #(
        .ROBsize (8),
        .DATA_W  (32),
        .REG_W   (5)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .rob_if    (bus)
`ifdef ROB_COMMIT_STATS_EN
        ,
        .retired_count_o (retired_count),
        .flush_count_o   (flush_count)
`endif
    );

    typedef struct {
        logic        av;
        logic [2:0]  at;
        logic [4:0]  ad;
        logic        ah;
        logic        wv;
        logic [2:0]  wt;
        logic [31:0] wd;
        logic        we;
        logic [2:0]  hd;
        logic        rdy;
        logic        cv;
        logic [4:0]  cdest;
        logic        cwe;
        logic [31:0] cdata;
        logic        uh;
        logic        fl;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic av, input logic [2:0] at, input logic [4:0] ad, input logic ah,
        input logic wv, input logic [2:0] wt, input logic [31:0] wd, input logic we,
        input logic [2:0] hd, input logic rdy,
        input logic cv, input logic [4:0] cdest, input logic cwe, input logic [31:0] cdata,
        input logic uh, input logic fl, input logic busy);
        vec_t v;
        v.av = av; v.at = at; v.ad = ad; v.ah = ah;
        v.wv = wv; v.wt = wt; v.wd = wd; v.we = we;
        v.hd = hd; v.rdy = rdy;
        v.cv = cv; v.cdest = cdest; v.cwe = cwe; v.cdata = cdata;
        v.uh = uh; v.fl = fl; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.alloc_valid_i    = v.av;
        bus.alloc_tag_i      = v.at;
        bus.alloc_dest_i     = v.ad;
        bus.alloc_has_dest_i = v.ah;
        bus.wb_valid_i       = v.wv;
        bus.wb_tag_i         = v.wt;
        bus.wb_data_i        = v.wd;
        bus.wb_exc_i         = v.we;
        bus.head_i           = v.hd;
        bus.commit_ready_i   = v.rdy;
    endtask

    // Drive, check mid-cycle on the falling edge, then let the rising edge update state.
    task automatic step(input vec_t v, input int idx);
        drive(v);
        @(negedge clk);
        chk($sformatf("v%0d commit_valid", idx), 32'(bus.commit_valid_o), 32'(v.cv));
        chk($sformatf("v%0d update_head", idx), 32'(bus.update_head_o), 32'(v.uh));
        chk($sformatf("v%0d flush", idx), 32'(bus.flush_o), 32'(v.fl));
        chk($sformatf("v%0d busy", idx), 32'(bus.busy_o), 32'(v.busy));
        chk($sformatf("v%0d commit_we", idx), 32'(bus.commit_we_o), 32'(v.cwe));
        if (v.cv) begin
            chk($sformatf("v%0d commit_tag", idx), 32'(bus.commit_tag_o), 32'(v.hd));
            chk($sformatf("v%0d commit_dest", idx), 32'(bus.commit_dest_o), 32'(v.cdest));
            chk($sformatf("v%0d commit_data", idx), bus.commit_data_o, v.cdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0,0,0);
        drive(idle);

        // av at ad ah  wv wt wd we  hd rdy  cv cdest cwe cdata uh fl busy
        // in-order basic commit
        tbl.push_back(mk(1,0,3,1, 0,0,0,0,        0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,4,1, 0,0,0,0,        0,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,2,5,1, 1,0,32'hA5,0,   0,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        0,1, 1,3,1,32'hA5,1,0,1));
        // out-of-order completion
        tbl.push_back(mk(0,0,0,0, 1,2,32'h22,0,   1,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 1,1,32'h11,0,   1,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,1, 1,4,1,32'h11,1,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        2,1, 1,5,1,32'h22,1,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        3,1, 0,0,0,0,0,0,0));
        // back-pressure on a no-dest entry
        tbl.push_back(mk(1,3,7,0, 0,0,0,0,        3,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,3,32'hDEAD,0, 3,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        3,0, 1,7,0,32'hDEAD,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        3,0, 1,7,0,32'hDEAD,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        3,0, 1,7,0,32'hDEAD,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        3,1, 1,7,0,32'hDEAD,1,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        4,1, 0,0,0,0,0,0,0));
        // exception at head, flush, alloc/wb dropped during flush
        tbl.push_back(mk(1,4,9,1, 0,0,0,0,        4,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,5,10,1, 1,4,32'h1,1,   4,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        4,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,6,1,1, 1,5,32'h5,0,    4,1, 0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        6,1, 0,0,0,0,0,0,0));
        // wrap-around 6,7,0,1
        tbl.push_back(mk(1,6,16,1, 0,0,0,0,       6,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,7,17,1, 1,6,32'h60,0,  6,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,18,1, 1,7,32'h70,0,  6,1, 1,16,1,32'h60,1,0,1));
        tbl.push_back(mk(1,1,19,1, 1,0,32'h80,0,  7,1, 1,17,1,32'h70,1,0,1));
        tbl.push_back(mk(0,0,0,0, 1,1,32'h90,0,   0,1, 1,18,1,32'h80,1,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,1, 1,19,1,32'h90,1,0,1));
        // alloc vs commit-clear and alloc vs wb on the same index
        tbl.push_back(mk(1,2,20,1, 0,0,0,0,       2,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,2,32'hAA,0,   2,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,2,21,1, 0,0,0,0,       2,1, 1,20,1,32'hAA,1,0,1));
        tbl.push_back(mk(1,2,22,1, 1,2,32'hBB,0,  2,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        2,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 1,2,32'hCC,0,   2,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        2,1, 1,22,1,32'hCC,1,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        3,1, 0,0,0,0,0,0,0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset commit_valid", 32'(bus.commit_valid_o), 32'd0);
        chk("reset commit_we", 32'(bus.commit_we_o), 32'd0);
        chk("reset update_head", 32'(bus.update_head_o), 32'd0);
        chk("reset flush", 32'(bus.flush_o), 32'd0);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

`ifdef ROB_COMMIT_STATS_EN
        chk("retired_count", retired_count, 32'd10);
        chk("flush_count", 32'(flush_count), 32'd1);
`endif

        // reset asserted while the head is valid and done
        step(mk(1,3,2,1, 0,0,0,0,      3,1, 0,0,0,0,0,0,0), 100);
        step(mk(0,0,0,0, 1,3,32'h33,0, 3,1, 0,0,0,0,0,0,1), 101);
        drive(idle);
        bus.head_i = 3'd3;
        @(negedge clk);
        chk("pre-reset commit_valid", 32'(bus.commit_valid_o), 32'd1);
        chk("pre-reset update_head", 32'(bus.update_head_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset commit_valid", 32'(bus.commit_valid_o), 32'd0);
        chk("async reset update_head", 32'(bus.update_head_o), 32'd0);
        chk("async reset busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset commit_valid", 32'(bus.commit_valid_o), 32'd0);
        chk("post-reset busy", 32'(bus.busy_o), 32'd0);
`ifdef ROB_COMMIT_STATS_EN
        chk("post-reset retired_count", retired_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Reader/retire end of the reorder buffer.
- The dispatch side allocates entries at the tail. Execution units write results back by ROB tag.
- This block watches the entry at the head and retires completed entries in program order to the architectural register file.
- It pulses the head-advance request back to the ROB pointer manager and raises a pipeline flush when the head entry carries an exception.

Parameters:
- ROBsize, 16, number of ROB entries; must be a power of two.
- addrSize, $clog2(ROBsize), width of an entry index/tag.
- DATA_W, 32, result data width.
- REG_W, 5, architectural register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- alloc_valid_i  in  1  an entry is being allocated this cycle.
- alloc_tag_i  in  addrSize  index of the entry being allocated (the tail).
- alloc_dest_i  in  REG_W  destination architectural register.
- alloc_has_dest_i  in  1  entry writes a register (0 for stores/branches).
- wb_valid_i  in  1  execution writeback this cycle.
- wb_tag_i  in  addrSize  ROB index being completed.
- wb_data_i  in  DATA_W  result value.
- wb_exc_i  in  1  instruction raised an exception.
- head_i  in  addrSize  current head index from the pointer manager.
- commit_ready_i  in  1  register file accepts the commit.
- commit_valid_o  out  1  head entry retiring this cycle.
- commit_tag_o  out  addrSize  retiring index (equals head_i).
- commit_dest_o  out  REG_W  destination register.
- commit_we_o  out  1  register write enable (commit_valid_o & has_dest).
- commit_data_o  out  DATA_W  result value.
- update_head_o  out  1  one-cycle request to advance the head.
- flush_o  out  1  pipeline flush, registered.
- busy_o  out  1  at least one entry is valid.

Behaviour:
- Per-entry storage: valid, done, exc, has_dest, dest, data. Valid/done/exc are flops; data/dest may be plain flops without reset.
- Reset (async, reset_n_i=0):
  - all valid/done/exc cleared; FSM enters RUN.
  - outputs: commit_valid_o=0, commit_we_o=0, update_head_o=0, flush_o=0, busy_o=0; other outputs are don't-care but driven.
  - Reset mid-operation discards all in-flight entries.
- Allocate (alloc_valid_i in RUN): at the next edge, valid=1, done=0, exc=0, dest and has_dest captured. Ignored in FLUSH.
- Writeback (wb_valid_i): if entry wb_tag_i is valid, at the next edge done=1, data and exc captured. A writeback to an invalid entry is ignored. A writeback in FLUSH is ignored.
- Commit, combinational from registered state, RUN only:
  - commit_valid_o = valid[head_i] & done[head_i] & ~exc[head_i].
  - update_head_o = commit_valid_o & commit_ready_i. On that edge, valid[head_i] is cleared.
- Latency: writeback to head → commit_valid_o on the following cycle (1 cycle). Writebacks never bypass to commit.
- Back-pressure: commit_ready_i=0 holds commit_valid_o and its data stable; update_head_o=0.
- Exception: valid[head_i] & done[head_i] & exc[head_i] in RUN → transition to FLUSH. commit_valid_o=0 and update_head_o=0 in that cycle.
- FLUSH: lasts exactly one cycle. flush_o=1. All valid/done/exc clear at the end of the cycle. Return to RUN.
- Simultaneous events:
  - Alloc and commit-clear on the same index in one cycle: alloc wins, so valid stays 1 with new contents.
  - Wb and commit on different indices are independent.
  - Alloc and wb on the same index: alloc wins, done=0.
- Wrap-around: indices are modulo ROBsize; head_i wraps from ROBsize-1 to 0 with no special handling.
- busy_o = OR of all valid bits (registered state).

Optional Feature:
- Macro: ROB_COMMIT_STATS_EN.
- With the macro defined:
  - Adds output retired_count_o, 32 bits, reset to 0, +1 on every update_head_o, wraps at 2^32.
  - Adds output flush_count_o, 16 bits, reset to 0, +1 per FLUSH cycle, saturates at 16'hFFFF.
- Without the macro: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package rob_pkg:
  - rob_entry_t struct (valid, done, exc, has_dest, dest, data).
  - commit_state_t enum {RUN, FLUSH}.
  - default ROB_SIZE/DATA_W/REG_W constants, shared with the pointer manager.
- One sub-module, rob_status_array: the entry storage with alloc/writeback/clear write ports and a head read port.
- The FSM and commit logic stay in the top.

Test Plan (ROBsize=8):
- Reset, then alloc tags 0,1,2 with dest 3,4,5; wb tag 0 data 32'hA5 → next cycle commit_valid_o=1, commit_dest_o=3, commit_data_o=32'hA5, update_head_o=1.
- Out-of-order completion: wb tag 2 then tag 1 with head_i=1 → commit tag 1, then tag 2 on consecutive cycles; nothing commits before the tag 1 wb.
- commit_ready_i=0 for 3 cycles with head done → commit_valid_o stays 1 with data stable, update_head_o=0; release → one update_head_o pulse.
- Wb tag 0 with wb_exc_i=1 at head → no commit; flush_o=1 for exactly one cycle; busy_o=0 afterwards; allocs during the flush cycle are dropped.
- Wrap: fill tags 6,7,0,1 with head_i advancing 6→7→0→1, each written back → four commits in order; commit_tag_o shows 6,7,0,1.
- Assert reset_n_i mid-commit (head valid and done) → commit_valid_o and update_head_o drop immediately (asynchronously) and busy_o=0.
